lifo_port_arbiter: RTL

Two-port arbiter and sequencer in front of a single `LIFO_memory` instance. Two independent requesters issue push or pop transactions; the block grants them round-robin, drives the LIFO's `PUSH`/`POP`/`dataIn` strobes, and returns pop data or a rejection to the winner. It owns every LIFO control pin, so no requester touches the LIFO directly.

---
 rtl/lifo_port_arbiter.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/lifo_port_arbiter.sv
// lifo_port_arbiter
// Two-port round-robin arbiter and sequencer in front of a single LIFO.
// Each requester issues a push or a pop. The winner is latched and the LIFO
// strobes are driven. The requester then gets ACK (with pop data on DOUT) or
// NACK when its push meets a full LIFO or its pop meets an empty one.
// Optional feature: define LIFO_ARB_STATS_EN to build the per-requester ACK
// counters on GNT_CNT. Without it GNT_CNT is tied to zero.

module lifo_port_arbiter #(
   parameter int DATA_WIDTH = 8
) (
   input  logic                      Clk,
   input  logic                      Rst,
   input  logic [1:0]                REQ,
   input  logic [1:0]                OP,
   input  logic [2*DATA_WIDTH-1:0]   DIN,
   output logic [1:0]                ACK,
   output logic [1:0]                NACK,
   output logic [DATA_WIDTH-1:0]     DOUT,
   output logic                      BUSY,
   output logic                      L_PUSH,
   output logic                      L_POP,
   output logic [DATA_WIDTH-1:0]     L_DIN,
   input  logic [DATA_WIDTH-1:0]     L_DOUT,
   input  logic                      L_EMPTY,
   input  logic                      L_FULL,
   output logic [31:0]               GNT_CNT
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_ISSUE,
      S_WAIT,
      S_DONE
   } state_t;

   state_t                 r_state;
   logic                   r_ptr;
   logic                   r_winner;
   logic                   r_op;
   logic                   r_reject;
   logic                   r_busy;
   logic                   r_push;
   logic                   r_pop;
   logic [1:0]             r_ack;
   logic [1:0]             r_nack;
   logic [DATA_WIDTH-1:0]  r_dout;
   logic [DATA_WIDTH-1:0]  r_ldin;

   logic                   w_winner;
   logic                   w_op;
   logic                   w_reject;
   logic [DATA_WIDTH-1:0]  w_din;

   // Choose the requester to serve. The pointer only matters when both ask,
   // and the winner's operation, data and LIFO feasibility are derived here.
   always_comb begin
      w_winner = 1'b0;
      if (REQ == 2'b11) begin
         w_winner = r_ptr;
      end else if (REQ[1]) begin
         w_winner = 1'b1;
      end
      w_op     = OP[w_winner];
      w_din    = w_winner ? DIN[2*DATA_WIDTH-1:DATA_WIDTH] : DIN[DATA_WIDTH-1:0];
      w_reject = w_op ? L_EMPTY : L_FULL;
   end

   // Transaction sequencer. This block is the only master of the LIFO, so its
   // flags cannot move between the IDLE sampling cycle and the ISSUE cycle.
   // That lets the strobe and the reject decision be made at the IDLE edge,
   // so L_PUSH/L_POP are registers that are high exactly in the ISSUE cycle.
   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         r_state  <= S_IDLE;
         r_ptr    <= 1'b0;
         r_winner <= 1'b0;
         r_op     <= 1'b0;
         r_reject <= 1'b0;
         r_busy   <= 1'b0;
         r_push   <= 1'b0;
         r_pop    <= 1'b0;
         r_ack    <= 2'b00;
         r_nack   <= 2'b00;
         r_dout   <= '0;
         r_ldin   <= '0;
      end else begin
         r_push <= 1'b0;
         r_pop  <= 1'b0;
         r_ack  <= 2'b00;
         r_nack <= 2'b00;
         case (r_state)
            S_IDLE: begin
               if (|REQ) begin
                  r_winner <= w_winner;
                  r_op     <= w_op;
                  r_ldin   <= w_din;
                  r_reject <= w_reject;
                  r_push   <= ~w_op & ~w_reject;
                  r_pop    <= w_op & ~w_reject;
                  r_busy   <= 1'b1;
                  r_state  <= S_ISSUE;
               end
            end
            S_ISSUE: begin
               if (r_reject) begin
                  r_nack[r_winner] <= 1'b1;
                  r_state          <= S_DONE;
               end else if (r_op) begin
                  r_state <= S_WAIT;
               end else begin
                  r_ack[r_winner] <= 1'b1;
                  r_state         <= S_DONE;
               end
            end
            S_WAIT: begin
               r_dout          <= L_DOUT;
               r_ack[r_winner] <= 1'b1;
               r_state         <= S_DONE;
            end
            S_DONE: begin
               r_ptr   <= ~r_winner;
               r_busy  <= 1'b0;
               r_state <= S_IDLE;
            end
            default: begin
               r_busy  <= 1'b0;
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign ACK    = r_ack;
   assign NACK   = r_nack;
   assign DOUT   = r_dout;
   assign BUSY   = r_busy;
   assign L_PUSH = r_push;
   assign L_POP  = r_pop;
   assign L_DIN  = r_ldin;

`ifdef LIFO_ARB_STATS_EN
   logic [15:0] r_gntCnt0;
   logic [15:0] r_gntCnt1;

   // Saturating per-requester ACK counters. They advance on the ACK pulse
   // itself, so rejected transactions never count.
   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         r_gntCnt0 <= 16'd0;
         r_gntCnt1 <= 16'd0;
      end else begin
         if (r_ack[0] && (r_gntCnt0 != 16'hFFFF)) begin
            r_gntCnt0 <= r_gntCnt0 + 16'd1;
         end
         if (r_ack[1] && (r_gntCnt1 != 16'hFFFF)) begin
            r_gntCnt1 <= r_gntCnt1 + 16'd1;
         end
      end
   end

   assign GNT_CNT = {r_gntCnt1, r_gntCnt0};
`else
   assign GNT_CNT = 32'd0;
`endif

endmodule
